// File: rtl/inst_fetch_ctrl_if.sv
// Signal bundle between the PC stage, the instruction cache and the post-IF stage.
// master = inst_fetch_ctrl, slave = its environment (PC stage, cache, decode).
interface inst_fetch_ctrl_if;
    // Handshakes: a PC transfers on pc_valid_i & pc_ready_o, a cache read issues on
    // inst_req_o & inst_addr_ok_i, and the head entry retires on inst_valid_o & id_ready_i.
    logic [31:0] pc_i;
    logic        pc_valid_i;
    logic        pc_ready_o;
    logic        flush_i;
    logic        inst_req_o;
    logic [31:0] inst_addr_o;
    logic        inst_addr_ok_i;
    logic        inst_data_ok_i;
    logic [31:0] inst_rdata_i;
    logic        id_ready_i;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic [31:0] exception_type_o;
    logic        inst_valid_o;
    logic        fetch_stall_o;

    modport master (
        input  pc_i, pc_valid_i, flush_i, inst_addr_ok_i, inst_data_ok_i, inst_rdata_i, id_ready_i,
        output pc_ready_o, inst_req_o, inst_addr_o, pc_o, inst_o, exception_type_o,
        output inst_valid_o, fetch_stall_o
    );

    modport slave (
        output pc_i, pc_valid_i, flush_i, inst_addr_ok_i, inst_data_ok_i, inst_rdata_i, id_ready_i,
        input  pc_ready_o, inst_req_o, inst_addr_o, pc_o, inst_o, exception_type_o,
        input  inst_valid_o, fetch_stall_o
    );
endinterface

// File: rtl/inst_fetch_ctrl.sv
// In-order instruction-fetch queue with flush cancellation of in-flight cache replies.
// Define IF_ADDR_EXC_EN to turn misaligned PCs into AdEL exception entries.
module inst_fetch_ctrl #(
    parameter int MAX_OUT = 2
) (
    input  logic              clk,
    input  logic              resetn,
    inst_fetch_ctrl_if.master bus
);
    localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int CW = 3;
    localparam logic [PW-1:0] LAST = PW'(MAX_OUT - 1);

    logic [31:0]        pc_q   [MAX_OUT];
    logic [31:0]        inst_q [MAX_OUT];
    logic [MAX_OUT-1:0] exc_q;
    logic [MAX_OUT-1:0] done_q;
    logic [PW-1:0]      head_q;
    logic [PW-1:0]      alloc_q;
    logic [CW-1:0]      occ_q;
    logic [CW-1:0]      cancel_q;

    logic          free;
    logic          misaligned;
    logic          offer;
    logic          alloc_en;
    logic          pop_en;
    logic          drop_en;
    logic          fill_en;
    logic          head_valid;
    logic          fill_found;
    logic [PW-1:0] fill_idx;
    logic [PW-1:0] scan_idx;
    logic [CW-1:0] pend_cnt;
    logic [CW-1:0] cancel_flush;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + PW'(1);
    endfunction

`ifdef IF_ADDR_EXC_EN
    assign misaligned = (bus.pc_i[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    assign free     = ({1'b0, occ_q} + {1'b0, cancel_q}) < 4'(MAX_OUT);
    assign offer    = resetn & bus.pc_valid_i & ~bus.flush_i & free;
    assign alloc_en = offer & (misaligned | bus.inst_addr_ok_i);

    assign bus.inst_req_o  = offer & ~misaligned;
    assign bus.inst_addr_o = bus.pc_i;
    assign bus.pc_ready_o  = alloc_en;

    // Oldest live entry still waiting for its reply, plus how many such entries exist.
    always_comb begin
        fill_found = 1'b0;
        fill_idx   = head_q;
        pend_cnt   = '0;
        scan_idx   = head_q;
        for (int i = 0; i < MAX_OUT; i++) begin
            if ((CW'(i) < occ_q) && !done_q[scan_idx]) begin
                if (!fill_found) begin
                    fill_idx   = scan_idx;
                    fill_found = 1'b1;
                end
                pend_cnt = pend_cnt + CW'(1);
            end
            scan_idx = ptr_inc(scan_idx);
        end
    end

    assign drop_en = bus.inst_data_ok_i & (cancel_q != '0);
    assign fill_en = bus.inst_data_ok_i & (cancel_q == '0) & fill_found;

    assign head_valid = (occ_q != '0) & done_q[head_q];
    assign pop_en     = head_valid & bus.id_ready_i & ~bus.flush_i;

    // Replies still owed by the cache once the queue is wiped: old debt plus unfilled entries.
    assign cancel_flush = cancel_q - CW'(drop_en) + pend_cnt - CW'(fill_en);

    assign bus.inst_valid_o     = head_valid;
    assign bus.fetch_stall_o    = (occ_q != '0) & ~done_q[head_q];
    assign bus.pc_o             = head_valid ? pc_q[head_q] : '0;
    assign bus.inst_o           = head_valid ? inst_q[head_q] : '0;
    assign bus.exception_type_o = (head_valid & exc_q[head_q]) ? 32'h0000_0010 : '0;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            head_q   <= '0;
            alloc_q  <= '0;
            occ_q    <= '0;
            cancel_q <= '0;
            exc_q    <= '0;
            done_q   <= '0;
        end else if (bus.flush_i) begin
            head_q   <= '0;
            alloc_q  <= '0;
            occ_q    <= '0;
            exc_q    <= '0;
            done_q   <= '0;
            cancel_q <= cancel_flush;
        end else begin
            if (alloc_en) begin
                exc_q[alloc_q]  <= misaligned;
                done_q[alloc_q] <= misaligned;
                alloc_q         <= ptr_inc(alloc_q);
            end
            if (fill_en) begin
                done_q[fill_idx] <= 1'b1;
            end
            if (drop_en) begin
                cancel_q <= cancel_q - CW'(1);
            end
            if (pop_en) begin
                head_q <= ptr_inc(head_q);
            end
            occ_q <= occ_q + CW'(alloc_en) - CW'(pop_en);
        end
    end

    // Payload storage needs no reset: an entry is only read once its done flag is set.
    always_ff @(posedge clk) begin
        if (alloc_en) begin
            pc_q[alloc_q]   <= bus.pc_i;
            inst_q[alloc_q] <= '0;
        end
        if (fill_en) begin
            inst_q[fill_idx] <= bus.inst_rdata_i;
        end
    end
endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Bench for inst_fetch_ctrl: directed scenarios with literal expectations, then random
// traffic, all checked every cycle against a queue-based model of the fetch buffer.
module tb_inst_fetch_ctrl;
    localparam int MAX_OUT = 2;
`ifdef IF_ADDR_EXC_EN
    localparam bit EXC_EN = 1'b1;
`else
    localparam bit EXC_EN = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        exc;
        logic        done;
    } ent_t;

    logic clk;
    logic resetn;
    inst_fetch_ctrl_if bus ();

    inst_fetch_ctrl #(.MAX_OUT(MAX_OUT)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.master)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass;
    int n_total;

    ent_t        exp_q[$];
    int          cancel_m;
    logic [31:0] cache_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_in(input logic rn, input logic pv, input logic [31:0] pc, input logic fl,
                          input logic aok, input logic dok, input logic [31:0] rd, input logic idr);
        resetn             = rn;
        bus.pc_valid_i     = pv;
        bus.pc_i           = pc;
        bus.flush_i        = fl;
        bus.inst_addr_ok_i = aok;
        bus.inst_data_ok_i = dok;
        bus.inst_rdata_i   = rd;
        bus.id_ready_i     = idr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic chk_head(input string nm, input logic v, input logic [31:0] pc,
                            input logic [31:0] inst, input logic [31:0] exc);
        chk({nm, "_valid"}, 32'(bus.inst_valid_o), 32'(v));
        chk({nm, "_pc"}, bus.pc_o, pc);
        chk({nm, "_inst"}, bus.inst_o, inst);
        chk({nm, "_exc"}, bus.exception_type_o, exc);
    endtask

    // ---------------- cache responder state ----------------
    always @(negedge clk) begin
        if (!resetn) begin
            cache_q.delete();
        end else begin
            if (bus.inst_data_ok_i && cache_q.size() > 0) cache_q.delete(0);
            if (bus.inst_req_o && bus.inst_addr_ok_i) cache_q.push_back($urandom());
        end
    end

    // ---------------- model + scoreboard ----------------
    always @(negedge clk) begin : model
        bit   mis, free_m, offer_m, hv, filled;
        int   pend;
        ent_t e;
        mis     = EXC_EN && (bus.pc_i[1:0] != 2'b00);
        free_m  = (exp_q.size() + cancel_m) < MAX_OUT;
        offer_m = resetn && bus.pc_valid_i && !bus.flush_i && free_m;
        hv      = (exp_q.size() > 0) && exp_q[0].done;

        chk("inst_req", 32'(bus.inst_req_o), 32'(offer_m && !mis));
        chk("pc_ready", 32'(bus.pc_ready_o), 32'(offer_m && (mis || bus.inst_addr_ok_i)));
        chk("inst_addr", bus.inst_addr_o, bus.pc_i);
        chk("inst_valid", 32'(bus.inst_valid_o), 32'(hv));
        chk("fetch_stall", 32'(bus.fetch_stall_o), 32'((exp_q.size() > 0) && !exp_q[0].done));
        chk("pc_o", bus.pc_o, hv ? exp_q[0].pc : 32'h0);
        chk("inst_o", bus.inst_o, hv ? exp_q[0].inst : 32'h0);
        chk("exc_type", bus.exception_type_o, (hv && exp_q[0].exc) ? 32'h10 : 32'h0);

        if (!resetn) begin
            exp_q.delete();
            cancel_m = 0;
        end else begin
            if (bus.inst_data_ok_i) begin
                if (cancel_m > 0) begin
                    cancel_m--;
                end else begin
                    filled = 1'b0;
                    for (int i = 0; i < exp_q.size(); i++) begin
                        if (!filled && !exp_q[i].done) begin
                            e        = exp_q[i];
                            e.inst   = bus.inst_rdata_i;
                            e.done   = 1'b1;
                            exp_q[i] = e;
                            filled   = 1'b1;
                        end
                    end
                end
            end
            if (bus.flush_i) begin
                pend = 0;
                foreach (exp_q[i]) if (!exp_q[i].done) pend++;
                cancel_m += pend;
                exp_q.delete();
            end else begin
                if (hv && bus.id_ready_i) exp_q.delete(0);
                if (offer_m && (mis || bus.inst_addr_ok_i))
                    exp_q.push_back('{pc: bus.pc_i, inst: 32'h0, exc: mis, done: mis});
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] r;
        n_pass   = 0;
        n_total  = 0;
        cancel_m = 0;
        set_in(0, 1, 32'hBFC0_0000, 0, 1, 0, 0, 0);
        tick();
        tick();
        settle();
        chk("rst_req", 32'(bus.inst_req_o), 32'h0);
        chk("rst_ready", 32'(bus.pc_ready_o), 32'h0);
        chk("rst_stall", 32'(bus.fetch_stall_o), 32'h0);
        chk_head("rst", 0, 0, 0, 0);
        tick();

        // first fetch, minimum latency
        set_in(1, 1, 32'hBFC0_0000, 0, 1, 0, 0, 0); settle();
        chk("t1_req", 32'(bus.inst_req_o), 32'h1);
        chk("t1_addr", bus.inst_addr_o, 32'hBFC0_0000);
        tick();
        set_in(1, 0, 0, 0, 0, 1, 32'h3C1D_0001, 0); settle();
        chk("t1_stall", 32'(bus.fetch_stall_o), 32'h1);
        chk("t1_wait_valid", 32'(bus.inst_valid_o), 32'h0);
        tick();
        set_in(1, 0, 0, 0, 0, 0, 0, 1); settle();
        chk_head("t1", 1, 32'hBFC0_0000, 32'h3C1D_0001, 0);
        tick();

        // full queue, hold and release
        set_in(1, 1, 32'h100, 0, 1, 0, 0, 0); tick();
        set_in(1, 1, 32'h104, 0, 1, 0, 0, 0); tick();
        set_in(1, 1, 32'h108, 0, 1, 0, 0, 0); settle();
        chk("t2_full_req", 32'(bus.inst_req_o), 32'h0);
        chk("t2_full_ready", 32'(bus.pc_ready_o), 32'h0);
        tick();
        set_in(1, 1, 32'h108, 0, 1, 1, 32'hA100, 0); tick();
        set_in(1, 1, 32'h108, 0, 1, 1, 32'hA104, 0); settle();
        chk_head("t2_a", 1, 32'h100, 32'hA100, 0);
        tick();
        set_in(1, 1, 32'h108, 0, 1, 0, 0, 0); settle();
        chk_head("t2_hold", 1, 32'h100, 32'hA100, 0);
        tick();
        set_in(1, 1, 32'h108, 0, 1, 0, 0, 1); settle();
        chk("t2_pop_req", 32'(bus.inst_req_o), 32'h0);
        chk_head("t2_pop", 1, 32'h100, 32'hA100, 0);
        tick();
        set_in(1, 0, 0, 0, 0, 0, 0, 0); settle();
        chk_head("t2_b", 1, 32'h104, 32'hA104, 0);
        tick();
        set_in(1, 0, 0, 0, 0, 0, 0, 1); tick();

        // flush with both replies outstanding
        set_in(1, 1, 32'h200, 0, 1, 0, 0, 0); tick();
        set_in(1, 1, 32'h204, 0, 1, 0, 0, 0); tick();
        set_in(1, 0, 0, 1, 0, 0, 0, 0); tick();
        set_in(1, 1, 32'h300, 0, 1, 1, 32'hDEAD_0200, 1); settle();
        chk("t3_cancel2_req", 32'(bus.inst_req_o), 32'h0);
        tick();
        set_in(1, 1, 32'h300, 0, 1, 1, 32'hDEAD_0204, 1); settle();
        chk("t3_req", 32'(bus.inst_req_o), 32'h1);
        chk("t3_no_stale", 32'(bus.inst_valid_o), 32'h0);
        tick();
        set_in(1, 0, 0, 0, 0, 1, 32'h3000_0300, 1); settle();
        chk("t3_stall", 32'(bus.fetch_stall_o), 32'h1);
        tick();
        set_in(1, 0, 0, 0, 0, 0, 0, 1); settle();
        chk_head("t3", 1, 32'h300, 32'h3000_0300, 0);
        tick();

        // flush coinciding with the first reply
        set_in(1, 1, 32'h200, 0, 1, 0, 0, 0); tick();
        set_in(1, 1, 32'h204, 0, 1, 0, 0, 0); tick();
        set_in(1, 0, 0, 1, 0, 1, 32'hDEAD_0200, 1); tick();
        set_in(1, 1, 32'h400, 0, 1, 0, 0, 1); settle();
        chk("t4_cancel1_req", 32'(bus.inst_req_o), 32'h1);
        tick();
        set_in(1, 1, 32'h404, 0, 1, 1, 32'hDEAD_0204, 1); settle();
        chk("t4_full_req", 32'(bus.inst_req_o), 32'h0);
        chk("t4_no_stale", 32'(bus.inst_valid_o), 32'h0);
        tick();
        set_in(1, 0, 0, 0, 0, 1, 32'h4000_0400, 1); settle();
        chk("t4_stall", 32'(bus.fetch_stall_o), 32'h1);
        tick();
        set_in(1, 0, 0, 0, 0, 0, 0, 1); settle();
        chk_head("t4", 1, 32'h400, 32'h4000_0400, 0);
        tick();

        // misaligned PC
`ifdef IF_ADDR_EXC_EN
        set_in(1, 1, 32'h402, 0, 1, 0, 0, 0); settle();
        chk("t5_req", 32'(bus.inst_req_o), 32'h0);
        chk("t5_ready", 32'(bus.pc_ready_o), 32'h1);
        tick();
        set_in(1, 0, 0, 0, 0, 0, 0, 1); settle();
        chk_head("t5", 1, 32'h402, 32'h0, 32'h10);
        tick();
`else
        set_in(1, 1, 32'h402, 0, 1, 0, 0, 0); settle();
        chk("t5_req", 32'(bus.inst_req_o), 32'h1);
        chk("t5_addr", bus.inst_addr_o, 32'h402);
        tick();
        set_in(1, 0, 0, 0, 0, 1, 32'h1111_2222, 0); tick();
        set_in(1, 0, 0, 0, 0, 0, 0, 1); settle();
        chk_head("t5", 1, 32'h402, 32'h1111_2222, 0);
        tick();
`endif

        // reset with two fetches in flight
        set_in(1, 1, 32'h600, 0, 1, 0, 0, 0); tick();
        set_in(1, 1, 32'h604, 0, 1, 0, 0, 0); tick();
        set_in(0, 1, 32'h608, 0, 1, 0, 0, 1); settle();
        chk("t6_rst_req", 32'(bus.inst_req_o), 32'h0);
        chk("t6_rst_ready", 32'(bus.pc_ready_o), 32'h0);
        tick();
        set_in(1, 0, 0, 0, 0, 0, 0, 1); settle();
        chk("t6_stall", 32'(bus.fetch_stall_o), 32'h0);
        chk_head("t6_clr", 0, 0, 0, 0);
        tick();
        set_in(1, 1, 32'h700, 0, 1, 0, 0, 1); tick();
        set_in(1, 0, 0, 0, 0, 1, 32'h7777_0700, 1); tick();
        set_in(1, 0, 0, 0, 0, 0, 0, 1); settle();
        chk_head("t6", 1, 32'h700, 32'h7777_0700, 0);
        tick();

        // random traffic against the model
        set_in(0, 0, 0, 0, 0, 0, 0, 0); tick();
        for (int c = 0; c < 4000; c++) begin
            r = $urandom();
            resetn             = ($urandom_range(0, 299) != 0);
            bus.pc_valid_i     = ($urandom_range(0, 3) != 0);
            bus.pc_i           = {r[31:2], ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00};
            bus.flush_i        = ($urandom_range(0, 19) == 0);
            bus.inst_addr_ok_i = ($urandom_range(0, 2) != 0);
            bus.inst_data_ok_i = resetn && (cache_q.size() > 0) && ($urandom_range(0, 2) != 0);
            bus.inst_rdata_i   = (cache_q.size() > 0) ? cache_q[0] : $urandom();
            bus.id_ready_i     = ($urandom_range(0, 3) != 0);
            tick();
        end

        set_in(1, 0, 0, 0, 0, 0, 0, 0);
        tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
